fft_reorder_buffer: RTL and testbench
=====================================

FFT_REORDER_BUFFER -- requirements
Module: fft_reorder_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: width of each real/imag sample.
REQ-002 SHALL have parameter FFT_POINTS, default 64: frame length, power of two, 8..1024; ADDR_WIDTH = log2(FFT_POINTS).
REQ-003 SHALL have port clk, input, 1: single system clock, all logic on rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: sample from final FFT stage present this cycle; no backpressure upstream.
REQ-006 SHALL have ports in_real and in_imag, input, DATA_WIDTH each: sample data.
REQ-007 SHALL have port in_addr, input, ADDR_WIDTH: stream position of the sample; frequency bin = bit-reverse(in_addr).
REQ-008 SHALL have ports out_valid (output, 1) and out_ready (input, 1): output handshake; transfer when both high.
REQ-009 SHALL have ports out_real and out_imag, output, DATA_WIDTH each: natural-order bin data.
REQ-010 SHALL have port out_index, output, ADDR_WIDTH: bin number of the current output.
REQ-011 SHALL have port out_last, output, 1: high with out_index = FFT_POINTS-1.
REQ-012 SHALL have port overflow, output, 1: sticky flag, set on a dropped input sample.

Function
REQ-013 SHALL hold two banks of FFT_POINTS complex entries (ping-pong); each bank state is EMPTY, FILLING or FULL.
REQ-014 SHALL write an accepted sample into the write bank at location bit-reverse(in_addr); a duplicate address overwrites (last write wins).
REQ-015 SHALL count accepted writes; on the FFT_POINTS-th accepted write the bank becomes FULL at that edge and the write-bank pointer toggles.
REQ-016 SHALL accept in_valid when the write bank is not FULL, or when it is being released by the final output handshake in the same cycle.
REQ-017 SHALL otherwise drop the sample, leave the write count unchanged and set overflow until reset.
REQ-018 SHALL run a read FSM with states R_IDLE and R_STREAM.
REQ-019 R_IDLE -> R_STREAM when the read bank is FULL; the read address starts at 0.
REQ-020 The first out_valid SHALL assert 2 cycles after the edge at which the bank became FULL, which covers the synchronous RAM read plus the output register.
REQ-021 SHALL keep out_valid, out_real, out_imag, out_index and out_last stable while out_valid=1 and out_ready=0.
REQ-022 SHALL sustain one output per cycle while out_ready=1, using a prefetch or skid stage; there are no bubbles inside a frame.
REQ-023 On the out_last handshake, the read bank SHALL become EMPTY and the read pointer toggle; if the other bank is FULL, index 0 of it SHALL follow with at most 1 bubble cycle, otherwise the FSM returns to R_IDLE.
REQ-024 SHALL allow simultaneous write completion on one bank and read completion on the other in the same cycle, with both state updates applied.
REQ-025 SHALL pass data unmodified: no scaling or rounding.

Reset
REQ-026 On rst: both banks EMPTY, write bank 0, write count 0, read FSM R_IDLE, out_valid=0, out_last=0, out_index=0, out_real=0, out_imag=0, overflow=0.
REQ-027 RAM contents SHALL NOT be reset; rst asserted mid-frame discards partial and pending frames.

Structure
REQ-028 Shared package fft_pkg SHALL hold ADDR_WIDTH derivation, the bank-state and read-FSM encodings, and the bit-reverse function.
REQ-029 SHALL instantiate one sub-module fft_reorder_ram: simple dual-port, 2*FFT_POINTS x 2*DATA_WIDTH, 1 write port, 1 synchronous read port, bank bit as address MSB.

Verification
REQ-030 N=64, in_addr=0..63 consecutive, in_real=in_addr, in_imag=-in_addr, out_ready=1 -> out_real sequence 0,32,16,48,8,...,63 at index 0..63, out_last only at index 63, overflow=0.
REQ-031 Three back-to-back frames, out_ready=1 -> 192 outputs, frame 2 starts within 1 cycle of frame 1 out_last, no drops.
REQ-032 Frame 1 written, out_ready=0 throughout, frame 2 written, then 1 more sample -> that sample dropped, overflow=1, frames 1 and 2 later drain intact.
REQ-033 out_ready toggled pseudo-randomly at 50% -> every output held stable while stalled, no duplicated or missing index.
REQ-034 rst pulsed after 20 writes of frame 1 -> outputs at reset values; next full frame reorders correctly with index 0 first.
REQ-035 Final write of frame 2 on the same cycle as frame 1 out_last handshake -> both banks update, frame 2 streams next, overflow=0.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT reorder buffer: address width derivation,
// bank/read-FSM encodings and the bit-reverse helper.
package fft_pkg;

  localparam int MAX_ADDR_WIDTH = 10;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_e;

  typedef enum logic {
    R_IDLE   = 1'b0,
    R_STREAM = 1'b1
  } rd_state_e;

  function automatic int addr_width(input int points);
    return $clog2(points);
  endfunction

  // Reverses the low 'width' bits of a; bits above 'width' come back as zero.
  function automatic logic [MAX_ADDR_WIDTH-1:0] bit_reverse(
    input logic [MAX_ADDR_WIDTH-1:0] a,
    input int                        width
  );
    logic [MAX_ADDR_WIDTH-1:0] r;
    for (int i = 0; i < MAX_ADDR_WIDTH; i++) r[i] = a[MAX_ADDR_WIDTH-1-i];
    return r >> (MAX_ADDR_WIDTH - width);
  endfunction

endpackage

// File: rtl/fft_reorder_ram.sv
// Simple dual-port RAM, one write port and one registered read port.
// The read register only updates when re_i is high, so it holds data during stalls.
module fft_reorder_ram #(
  parameter int DW = 32,
  parameter int AW = 7
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/fft_reorder_buffer.sv
// Ping-pong bit-reversal reorder buffer: FFT output in stream order goes in,
// natural-order bins come out over a valid/ready handshake.
module fft_reorder_buffer
  import fft_pkg::*;
#(
  parameter int  DATA_WIDTH = 16,
  parameter int  FFT_POINTS = 64,
  localparam int ADDR_WIDTH = addr_width(FFT_POINTS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_real,
  input  logic [DATA_WIDTH-1:0] in_imag,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_real,
  output logic [DATA_WIDTH-1:0] out_imag,
  output logic [ADDR_WIDTH-1:0] out_index,
  output logic                  out_last,
  output logic                  overflow,
  output logic                  dbg_rd_state
);

  // Handshake: a transfer happens on a rising edge where out_valid and out_ready
  // are both high; while out_valid=1 and out_ready=0 every output holds.

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FFT_POINTS - 1);

  bank_state_e bank_q [2];
  bank_state_e bank_d [2];
  logic                  wr_bank_q, wr_bank_d;
  logic [ADDR_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
  logic                  ovf_q, ovf_d;
  rd_state_e             rd_state_q, rd_state_d;
  logic                  rd_bank_q, rd_bank_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  rd_more_q, rd_more_d;
  logic                  s1_valid_q, s1_valid_d;
  logic [ADDR_WIDTH-1:0] s1_idx_q, s1_idx_d;
  logic                  s1_last_q, s1_last_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_real_q, out_real_d, out_imag_q, out_imag_d;
  logic [ADDR_WIDTH-1:0] out_idx_q, out_idx_d;
  logic                  out_last_q, out_last_d;

  logic                    out_adv, last_hs, release_wr, accept;
  logic                    start, start_bank, issue, ram_re;
  logic [ADDR_WIDTH:0]     ram_raddr;
  logic [ADDR_WIDTH-1:0]   wr_addr_lo;
  logic [2*DATA_WIDTH-1:0] ram_rdata;

  assign wr_addr_lo = ADDR_WIDTH'(bit_reverse(MAX_ADDR_WIDTH'(in_addr), ADDR_WIDTH));

  always_comb begin
    out_adv    = !out_valid_q || out_ready;
    last_hs    = out_valid_q && out_ready && out_last_q;
    release_wr = last_hs && (rd_bank_q == wr_bank_q);
    accept     = in_valid && ((bank_q[wr_bank_q] != BANK_FULL) || release_wr);

    bank_d[0] = bank_q[0];
    bank_d[1] = bank_q[1];
    wr_bank_d = wr_bank_q;
    wr_cnt_d  = wr_cnt_q;
    ovf_d     = ovf_q || (in_valid && !accept);
    if (last_hs) bank_d[rd_bank_q] = BANK_EMPTY;
    // A write into the bank released this same cycle overrides the EMPTY above.
    if (accept) begin
      if (wr_cnt_q == LAST_ADDR) begin
        bank_d[wr_bank_q] = BANK_FULL;
        wr_cnt_d          = '0;
        wr_bank_d         = ~wr_bank_q;
      end else begin
        bank_d[wr_bank_q] = BANK_FILLING;
        wr_cnt_d          = wr_cnt_q + 1'b1;
      end
    end

    // Frame start: from idle, or straight after the last handshake when the
    // other bank is already full, which limits the gap to one bubble.
    start      = 1'b0;
    start_bank = rd_bank_q;
    if (rd_state_q == R_IDLE) begin
      start = (bank_q[rd_bank_q] == BANK_FULL);
    end else if (last_hs) begin
      start      = (bank_q[~rd_bank_q] == BANK_FULL);
      start_bank = ~rd_bank_q;
    end
    issue     = (rd_state_q == R_STREAM) && rd_more_q && (!s1_valid_q || out_adv);
    ram_re    = start || issue;
    ram_raddr = start ? {start_bank, {ADDR_WIDTH{1'b0}}} : {rd_bank_q, rd_addr_q};

    rd_bank_d  = last_hs ? ~rd_bank_q : rd_bank_q;
    rd_state_d = rd_state_q;
    if (start)        rd_state_d = R_STREAM;
    else if (last_hs) rd_state_d = R_IDLE;

    rd_addr_d = rd_addr_q;
    rd_more_d = rd_more_q;
    if (start) begin
      rd_addr_d = ADDR_WIDTH'(1);
      rd_more_d = 1'b1;
    end else if (issue) begin
      rd_addr_d = rd_addr_q + 1'b1;
      rd_more_d = (rd_addr_q != LAST_ADDR);
    end

    s1_valid_d = s1_valid_q;
    s1_idx_d   = s1_idx_q;
    s1_last_d  = s1_last_q;
    if (ram_re) begin
      s1_valid_d = 1'b1;
      s1_idx_d   = start ? '0 : rd_addr_q;
      s1_last_d  = !start && (rd_addr_q == LAST_ADDR);
    end else if (out_adv) begin
      s1_valid_d = 1'b0;
    end

    out_valid_d = out_valid_q;
    out_real_d  = out_real_q;
    out_imag_d  = out_imag_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    if (out_adv) begin
      out_valid_d = s1_valid_q;
      out_last_d  = s1_valid_q && s1_last_q;
      if (s1_valid_q) begin
        out_real_d = ram_rdata[2*DATA_WIDTH-1:DATA_WIDTH];
        out_imag_d = ram_rdata[DATA_WIDTH-1:0];
        out_idx_d  = s1_idx_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_q[0]   <= BANK_EMPTY;
      bank_q[1]   <= BANK_EMPTY;
      wr_bank_q   <= 1'b0;
      wr_cnt_q    <= '0;
      ovf_q       <= 1'b0;
      rd_state_q  <= R_IDLE;
      rd_bank_q   <= 1'b0;
      rd_addr_q   <= '0;
      rd_more_q   <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_idx_q    <= '0;
      s1_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_real_q  <= '0;
      out_imag_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      bank_q[0]   <= bank_d[0];
      bank_q[1]   <= bank_d[1];
      wr_bank_q   <= wr_bank_d;
      wr_cnt_q    <= wr_cnt_d;
      ovf_q       <= ovf_d;
      rd_state_q  <= rd_state_d;
      rd_bank_q   <= rd_bank_d;
      rd_addr_q   <= rd_addr_d;
      rd_more_q   <= rd_more_d;
      s1_valid_q  <= s1_valid_d;
      s1_idx_q    <= s1_idx_d;
      s1_last_q   <= s1_last_d;
      out_valid_q <= out_valid_d;
      out_real_q  <= out_real_d;
      out_imag_q  <= out_imag_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
    end
  end

  fft_reorder_ram #(
    .DW(2 * DATA_WIDTH),
    .AW(ADDR_WIDTH + 1)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (accept),
    .waddr_i ({wr_bank_q, wr_addr_lo}),
    .wdata_i ({in_real, in_imag}),
    .re_i    (ram_re),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  assign out_valid    = out_valid_q;
  assign out_real     = out_real_q;
  assign out_imag     = out_imag_q;
  assign out_index    = out_idx_q;
  assign out_last     = out_last_q;
  assign overflow     = ovf_q;
  assign dbg_rd_state = rd_state_q;

endmodule

// File: tb/tb_fft_reorder_buffer.sv
// Directed bench for fft_reorder_buffer (N=64): reorder, back-to-back frames,
// overflow, stalls, mid-frame reset and coincident write/read completion.
module tb_fft_reorder_buffer;

  localparam int DW = 16;
  localparam int N  = 64;
  localparam int AW = 6;
  localparam int W  = AW + 2 * DW + 1;

  logic          clk = 1'b0;
  logic          rst, in_valid, out_valid, out_ready, out_last, overflow, dbg_rd_state;
  logic [DW-1:0] in_real, in_imag, out_real, out_imag;
  logic [AW-1:0] in_addr, out_index;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  int           obs_cyc_q[$];

  fft_reorder_buffer #(.DATA_WIDTH(DW), .FFT_POINTS(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_real      (in_real),
    .in_imag      (in_imag),
    .in_addr      (in_addr),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_real     (out_real),
    .out_imag     (out_imag),
    .out_index    (out_index),
    .out_last     (out_last),
    .overflow     (overflow),
    .dbg_rd_state (dbg_rd_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Handshakes are recorded at the negedge and stamped with the edge count
  // of the rising edge on which the transfer takes place.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      obs_q.push_back({out_index, out_real, out_imag, out_last});
      obs_cyc_q.push_back(cyc + 1);
    end
  end

  function automatic int tb_bitrev(input int v);
    int r = 0;
    for (int k = 0; k < AW; k++) if (v[k]) r |= 1 << (AW - 1 - k);
    return r;
  endfunction

  // driver tasks
  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    obs_q.delete();
    obs_cyc_q.delete();
    exp_q.delete();
  endtask

  task automatic write_sample(input int a, input int v);
    in_valid = 1'b1;
    in_addr  = AW'(a);
    in_real  = DW'(v);
    in_imag  = DW'(-v);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic write_frame(input int base);
    for (int a = 0; a < N; a++) write_sample(a, base + a);
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input int base);
    for (int i = 0; i < N; i++) begin
      int v = base + tb_bitrev(i);
      exp_q.push_back({AW'(i), DW'(v), DW'(-v), 1'(i == N - 1)});
    end
  endtask

  task automatic wait_outputs(input int n, input int budget);
    int k = 0;
    while (obs_q.size() < n && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  // tests
  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    total++; if (out_last !== 1'b0) begin bad++; $display("FAIL rst_out_last got=%b exp=0", out_last); end
    total++; if (out_index !== '0) begin bad++; $display("FAIL rst_out_index got=%0d exp=0", out_index); end
    total++; if (out_real !== '0) begin bad++; $display("FAIL rst_out_real got=%h exp=0", out_real); end
    total++; if (out_imag !== '0) begin bad++; $display("FAIL rst_out_imag got=%h exp=0", out_imag); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow got=%b exp=0", overflow); end
    rst = 1'b0;
  endtask

  task automatic test_single_frame();
    logic [W-1:0] o;
    out_ready = 1'b1;
    push_frame(0);
    write_frame(0);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_full_edge got=%b exp=0", out_valid); end
    idle_cycle();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_plus1 got=%b exp=0", out_valid); end
    idle_cycle();
    total++;
    if (out_valid !== 1'b1 || out_index !== '0) begin
      bad++; $display("FAIL lat_plus2 got=%b/%0d exp=1/0", out_valid, out_index);
    end
    wait_outputs(N, 200);
    idle_cycle();
    total++; if (obs_q.size() != N) begin bad++; $display("FAIL single_count got=%0d exp=%0d", obs_q.size(), N); end
    while (exp_q.size() > 0) begin
      logic [W-1:0] e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      total++; if (o !== e) begin bad++; $display("FAIL single_data got=%h exp=%h", o, e); end
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_idle got=%b exp=0", out_valid); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL single_overflow got=%b exp=0", overflow); end
    obs_q.delete();
    obs_cyc_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] o;
    out_ready = 1'b1;
    push_frame(1000);
    push_frame(2000);
    push_frame(3000);
    write_frame(1000);
    idle_cycle();
    write_frame(2000);
    idle_cycle();
    write_frame(3000);
    wait_outputs(3 * N, 400);
    total++; if (obs_q.size() != 3 * N) begin bad++; $display("FAIL b2b_count got=%0d exp=%0d", obs_q.size(), 3 * N); end
    if (obs_cyc_q.size() >= 3 * N) begin
      for (int f = 1; f < 3; f++) begin
        int gap = obs_cyc_q[f * N] - obs_cyc_q[f * N - 1];
        total++; if (gap > 2) begin bad++; $display("FAIL b2b_gap%0d got=%0d exp<=2", f, gap); end
      end
    end
    while (exp_q.size() > 0) begin
      logic [W-1:0] e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      total++; if (o !== e) begin bad++; $display("FAIL b2b_data got=%h exp=%h", o, e); end
    end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL b2b_overflow got=%b exp=0", overflow); end
    obs_q.delete();
    obs_cyc_q.delete();
  endtask

  task automatic test_overflow();
    logic [W-1:0] o;
    out_ready = 1'b0;
    push_frame(100);
    push_frame(200);
    write_frame(100);
    write_frame(200);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_before got=%b exp=0", overflow); end
    write_sample(5, 999);
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    total++;
    if (out_valid !== 1'b1 || out_index !== '0 || out_real !== DW'(100)) begin
      bad++; $display("FAIL ovf_hold got=%b/%0d/%h exp=1/0/0064", out_valid, out_index, out_real);
    end
    out_ready = 1'b1;
    wait_outputs(2 * N, 400);
    push_frame(300);
    write_frame(300);
    wait_outputs(3 * N, 300);
    total++; if (obs_q.size() != 3 * N) begin bad++; $display("FAIL ovf_count got=%0d exp=%0d", obs_q.size(), 3 * N); end
    while (exp_q.size() > 0) begin
      logic [W-1:0] e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      total++; if (o !== e) begin bad++; $display("FAIL ovf_data got=%h exp=%h", o, e); end
    end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    obs_q.delete();
    obs_cyc_q.delete();
  endtask

  task automatic test_stall();
    logic [W-1:0] o;
    do_reset();
    push_frame(500);
    push_frame(600);
    fork
      begin
        write_frame(500);
        write_frame(600);
      end
      begin
        logic [W-1:0] snap = '0;
        logic         stalled = 1'b0;
        int           k = 0;
        while (obs_q.size() < 2 * N && k < 3000) begin
          if (stalled) begin
            total++;
            if ({out_valid, out_index, out_real, out_imag, out_last} !== {1'b1, snap}) begin
              bad++; $display("FAIL stall_hold got=%h exp=%h", {out_index, out_real, out_imag, out_last}, snap);
            end
          end
          snap      = {out_index, out_real, out_imag, out_last};
          out_ready = 1'($urandom_range(0, 1));
          stalled   = out_valid && !out_ready;
          @(posedge clk);
          #1;
          k++;
        end
      end
    join
    out_ready = 1'b1;
    total++; if (obs_q.size() != 2 * N) begin bad++; $display("FAIL stall_count got=%0d exp=%0d", obs_q.size(), 2 * N); end
    while (exp_q.size() > 0) begin
      logic [W-1:0] e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      total++; if (o !== e) begin bad++; $display("FAIL stall_data got=%h exp=%h", o, e); end
    end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL stall_overflow got=%b exp=0", overflow); end
    obs_q.delete();
    obs_cyc_q.delete();
  endtask

  task automatic test_reset_midframe();
    logic [W-1:0] o;
    do_reset();
    write_frame(7);
    for (int a = 0; a < 20; a++) write_sample(a, 70 + a);
    total++;
    if (out_valid !== 1'b1 || out_real !== DW'(7)) begin
      bad++; $display("FAIL mid_pending got=%b/%h exp=1/0007", out_valid, out_real);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({out_valid, out_last, out_index, out_real, out_imag, overflow} !== '0) begin
      bad++; $display("FAIL mid_rst_outputs got=%b/%b/%0d/%h/%h/%b exp=all zero",
                      out_valid, out_last, out_index, out_real, out_imag, overflow);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    obs_q.delete();
    obs_cyc_q.delete();
    out_ready = 1'b1;
    push_frame(50);
    write_frame(50);
    wait_outputs(N, 200);
    repeat (10) idle_cycle();
    total++; if (obs_q.size() != N) begin bad++; $display("FAIL mid_count got=%0d exp=%0d", obs_q.size(), N); end
    while (exp_q.size() > 0) begin
      logic [W-1:0] e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      total++; if (o !== e) begin bad++; $display("FAIL mid_data got=%h exp=%h", o, e); end
    end
    obs_q.delete();
    obs_cyc_q.delete();
  endtask

  task automatic test_simultaneous();
    logic [W-1:0] o;
    int           w_edge;
    do_reset();
    out_ready = 1'b1;
    push_frame(800);
    push_frame(900);
    write_frame(800);
    idle_cycle();
    idle_cycle();
    write_frame(900);
    w_edge = cyc;
    wait_outputs(2 * N, 400);
    total++; if (obs_q.size() != 2 * N) begin bad++; $display("FAIL sim_count got=%0d exp=%0d", obs_q.size(), 2 * N); end
    if (obs_cyc_q.size() >= N) begin
      total++;
      if (obs_cyc_q[N-1] != w_edge) begin
        bad++; $display("FAIL sim_align got=%0d exp=%0d", obs_cyc_q[N-1], w_edge);
      end
    end
    while (exp_q.size() > 0) begin
      logic [W-1:0] e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      total++; if (o !== e) begin bad++; $display("FAIL sim_data got=%h exp=%h", o, e); end
    end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL sim_overflow got=%b exp=0", overflow); end
    obs_q.delete();
    obs_cyc_q.delete();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_addr   = '0;
    in_real   = '0;
    in_imag   = '0;
    out_ready = 1'b0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_stall();
    test_reset_midframe();
    test_simultaneous();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
